// File: rtl/multi_channel_capture_timer.sv
// multi_channel_capture_timer: per-channel elapsed-time counters with capture FIFOs, alarms and a shared read port
module multi_channel_capture_timer #(
   parameter int TIMER_BITWIDTH = 32,
   parameter int NB_CHANNELS    = 10,
   parameter int CAPTURE_DEPTH  = 4,
   parameter int CH_W           = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1
) (
   input  logic                                  clk,
   input  logic                                  areset_n,
   input  logic                                  sreset,
   input  logic [NB_CHANNELS-1:0]                start_i,
   input  logic [NB_CHANNELS-1:0]                capture_i,
   input  logic [NB_CHANNELS-1:0]                rst_capture_i,
   input  logic [NB_CHANNELS-1:0]                alarm_en_i,
   input  logic [NB_CHANNELS-1:0]                alarm_periodic_i,
   input  logic [NB_CHANNELS*TIMER_BITWIDTH-1:0] alarm_value_i,
   input  logic                                  rd_req_i,
   input  logic [CH_W-1:0]                       rd_ch_i,
   output logic                                  rd_valid_o,
   output logic [TIMER_BITWIDTH-1:0]             rd_data_o,
   output logic [NB_CHANNELS-1:0]                rd_empty_o,
   output logic [NB_CHANNELS-1:0]                running_o,
   output logic [NB_CHANNELS-1:0]                alarm_o,
   output logic [NB_CHANNELS-1:0]                ovf_o,
   output logic [NB_CHANNELS-1:0]                wrap_o
);
   localparam int W  = TIMER_BITWIDTH;
   localparam int AW = $clog2(CAPTURE_DEPTH);
   typedef enum logic {IDLE, RUN} state_t;
   state_t                 state_q [NB_CHANNELS];
   state_t                 state_d [NB_CHANNELS];
   logic [W-1:0]           cnt_q [NB_CHANNELS];
   logic [W-1:0]           cnt_d [NB_CHANNELS];
   logic [AW:0]            wr_ptr_q [NB_CHANNELS];
   logic [AW:0]            wr_ptr_d [NB_CHANNELS];
   logic [AW:0]            rd_ptr_q [NB_CHANNELS];
   logic [AW:0]            rd_ptr_d [NB_CHANNELS];
   logic [W-1:0]           mem [NB_CHANNELS][CAPTURE_DEPTH];
   logic [NB_CHANNELS-1:0] armed_q, armed_d, alarm_d, wrap_d, ovf_d;
   logic [NB_CHANNELS-1:0] full, pop, push, match;
   logic                   rd_ok, rd_valid_d;
   logic [W-1:0]           rd_data_d;
   // FIFO occupancy, read-port selection and alarm match for every channel
   always_comb begin
      rd_ok = rd_req_i && (32'(rd_ch_i) < NB_CHANNELS);
      for (int c = 0; c < NB_CHANNELS; c++) begin
         rd_empty_o[c] = wr_ptr_q[c] == rd_ptr_q[c];
         full[c]       = wr_ptr_q[c] == {~rd_ptr_q[c][AW], rd_ptr_q[c][AW-1:0]};
         pop[c]        = rd_ok && rd_ch_i == CH_W'(c) && !rd_empty_o[c];
         push[c]       = capture_i[c] && !rst_capture_i[c] && (!full[c] || pop[c]);
         match[c]      = state_q[c] == RUN && armed_q[c] && cnt_q[c] == alarm_value_i[c*W +: W];
         running_o[c]  = state_q[c] == RUN;
      end
   end
   // Per-channel next state: rst_capture beats start, start beats alarm match, match beats counting
   always_comb begin
      rd_valid_d = |pop;
      rd_data_d  = rd_data_o;
      for (int c = 0; c < NB_CHANNELS; c++) begin
         if (pop[c]) rd_data_d = mem[c][rd_ptr_q[c][AW-1:0]];
         state_d[c]  = state_q[c];
         cnt_d[c]    = cnt_q[c];
         armed_d[c]  = armed_q[c] && alarm_en_i[c];
         alarm_d[c]  = 1'b0;
         wrap_d[c]   = wrap_o[c];
         ovf_d[c]    = ovf_o[c] || (capture_i[c] && full[c] && !pop[c]);
         wr_ptr_d[c] = wr_ptr_q[c] + (AW+1)'(push[c]);
         rd_ptr_d[c] = rd_ptr_q[c] + (AW+1)'(pop[c]);
         if (rst_capture_i[c] || sreset) begin
            state_d[c]  = IDLE;
            cnt_d[c]    = '0;
            armed_d[c]  = 1'b0;
            wrap_d[c]   = 1'b0;
            ovf_d[c]    = 1'b0;
            wr_ptr_d[c] = '0;
            rd_ptr_d[c] = '0;
         end else if (start_i[c]) begin
            state_d[c] = RUN;
            cnt_d[c]   = '0;
            armed_d[c] = alarm_en_i[c];
         end else if (match[c]) begin
            alarm_d[c] = 1'b1;
            state_d[c] = alarm_periodic_i[c] ? RUN : IDLE;
            cnt_d[c]   = alarm_periodic_i[c] ? '0 : cnt_q[c];
            armed_d[c] = alarm_periodic_i[c] && alarm_en_i[c];
         end else if (state_q[c] == RUN) begin
            cnt_d[c]  = cnt_q[c] + W'(1);
            wrap_d[c] = wrap_o[c] || (&cnt_q[c]);
         end
      end
      if (sreset) begin
         rd_valid_d = 1'b0;
         rd_data_d  = '0;
      end
   end
   // State registers; sreset is folded into the next-state logic above
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         for (int c = 0; c < NB_CHANNELS; c++) begin
            state_q[c]  <= IDLE;
            cnt_q[c]    <= '0;
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
         armed_q    <= '0;
         alarm_o    <= '0;
         ovf_o      <= '0;
         wrap_o     <= '0;
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
      end else begin
         for (int c = 0; c < NB_CHANNELS; c++) begin
            state_q[c]  <= state_d[c];
            cnt_q[c]    <= cnt_d[c];
            wr_ptr_q[c] <= wr_ptr_d[c];
            rd_ptr_q[c] <= rd_ptr_d[c];
         end
         armed_q    <= armed_d;
         alarm_o    <= alarm_d;
         ovf_o      <= ovf_d;
         wrap_o     <= wrap_d;
         rd_valid_o <= rd_valid_d;
         rd_data_o  <= rd_data_d;
      end
   end
   // Capture storage; contents are don't-care until pointers say otherwise
   always_ff @(posedge clk) begin
      for (int c = 0; c < NB_CHANNELS; c++)
         if (push[c]) mem[c][wr_ptr_q[c][AW-1:0]] <= cnt_q[c];
   end
endmodule

// File: tb/tb_multi_channel_capture_timer.sv
// tb_multi_channel_capture_timer: table-driven and directed checks of the capture timer
module tb_multi_channel_capture_timer;
   localparam int W = 32, NC = 4, D = 4, CW = 2, W8 = 8;
   logic              clk = 1'b0, areset_n = 1'b0, sreset = 1'b0;
   logic [NC-1:0]     start_i = '0, capture_i = '0, rst_capture_i = '0, alarm_en_i = '0, alarm_periodic_i = '0;
   logic [NC*W-1:0]   alarm_value_i = '0;
   logic [NC*W8-1:0]  alarm_value8 = '1;
   logic              rd_req_i = 1'b0;
   logic [CW-1:0]     rd_ch_i = '0;
   logic              rd_valid_o, rd_valid8;
   logic [W-1:0]      rd_data_o;
   logic [W8-1:0]     rd_data8;
   logic [NC-1:0]     rd_empty_o, running_o, alarm_o, ovf_o, wrap_o;
   logic [NC-1:0]     empty8, running8, alarm8, ovf8, wrap8;
   int                n_cmp = 0, n_bad = 0;

   typedef struct {
      logic [NC-1:0] st, cap, rc;
      logic          rd;
      logic [CW-1:0] ch;
      logic          v;
      logic [W-1:0]  d;
      logic [NC-1:0] emp, run;
   } vec_t;
   vec_t tbl [18];

   always #5 clk = ~clk;

   multi_channel_capture_timer #(.TIMER_BITWIDTH(W), .NB_CHANNELS(NC), .CAPTURE_DEPTH(D), .CH_W(CW)) dut (
      .clk(clk), .areset_n(areset_n), .sreset(sreset), .start_i(start_i), .capture_i(capture_i),
      .rst_capture_i(rst_capture_i), .alarm_en_i(alarm_en_i), .alarm_periodic_i(alarm_periodic_i),
      .alarm_value_i(alarm_value_i), .rd_req_i(rd_req_i), .rd_ch_i(rd_ch_i), .rd_valid_o(rd_valid_o),
      .rd_data_o(rd_data_o), .rd_empty_o(rd_empty_o), .running_o(running_o), .alarm_o(alarm_o),
      .ovf_o(ovf_o), .wrap_o(wrap_o));

   multi_channel_capture_timer #(.TIMER_BITWIDTH(W8), .NB_CHANNELS(NC), .CAPTURE_DEPTH(D), .CH_W(CW)) dut8 (
      .clk(clk), .areset_n(areset_n), .sreset(sreset), .start_i(start_i), .capture_i(capture_i),
      .rst_capture_i(rst_capture_i), .alarm_en_i(alarm_en_i), .alarm_periodic_i(alarm_periodic_i),
      .alarm_value_i(alarm_value8), .rd_req_i(rd_req_i), .rd_ch_i(rd_ch_i), .rd_valid_o(rd_valid8),
      .rd_data_o(rd_data8), .rd_empty_o(empty8), .running_o(running8), .alarm_o(alarm8),
      .ovf_o(ovf8), .wrap_o(wrap8));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_sreset();
      sreset = 1'b1;
      tick();
      sreset = 1'b0;
   endtask

   task automatic pop(input int ch, input logic ev, input logic [W-1:0] ed, input string nm);
      rd_req_i = 1'b1;
      rd_ch_i  = CW'(ch);
      tick();
      rd_req_i = 1'b0;
      chk({nm, "_valid"}, rd_valid_o, ev);
      if (ev) chk({nm, "_data"}, rd_data_o, ed);
   endtask

   initial begin
      int hits, at, last;
      logic run37, run38, gap_ok;
      //             st       cap      rc       rd ch     v  d   emp      run
      tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 4'b1111, 4'b0001};
      tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 4'b1111, 4'b0001};
      tbl[2]  = '{4'b0000, 4'b0001, 4'b0000, 0, 2'd0, 0, 0, 4'b1110, 4'b0001};
      tbl[3]  = '{4'b0010, 4'b0001, 4'b0000, 0, 2'd0, 0, 0, 4'b1110, 4'b0011};
      tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd0, 1, 1, 4'b1110, 4'b0011};
      tbl[5]  = '{4'b0000, 4'b0010, 4'b0000, 1, 2'd1, 0, 1, 4'b1100, 4'b0011};
      tbl[6]  = '{4'b0000, 4'b0001, 4'b0000, 1, 2'd0, 1, 2, 4'b1100, 4'b0011};
      tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd1, 1, 1, 4'b1110, 4'b0011};
      tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd1, 0, 1, 4'b1110, 4'b0011};
      tbl[9]  = '{4'b0001, 4'b0001, 4'b0001, 0, 2'd0, 0, 1, 4'b1111, 4'b0010};
      tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd0, 0, 1, 4'b1111, 4'b0010};
      tbl[11] = '{4'b0001, 4'b0010, 4'b0000, 0, 2'd0, 0, 1, 4'b1101, 4'b0011};
      tbl[12] = '{4'b0000, 4'b0010, 4'b0000, 0, 2'd0, 0, 1, 4'b1101, 4'b0011};
      tbl[13] = '{4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 0, 1, 4'b1100, 4'b0011};
      tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd1, 1, 7, 4'b1100, 4'b0011};
      tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd1, 1, 8, 4'b1110, 4'b0011};
      tbl[16] = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd0, 1, 1, 4'b1111, 4'b0011};
      tbl[17] = '{4'b0000, 4'b0000, 4'b0011, 0, 2'd0, 0, 1, 4'b1111, 4'b0000};

      // reset state
      repeat (2) @(negedge clk);
      areset_n = 1'b1;
      #1;
      chk("rst_valid", rd_valid_o, 0);
      chk("rst_data", rd_data_o, 0);
      chk("rst_empty", rd_empty_o, 4'b1111);
      chk("rst_running", running_o, 0);
      chk("rst_alarm", alarm_o, 0);
      chk("rst_ovf", ovf_o, 0);
      chk("rst_wrap", wrap_o, 0);

      // table-driven single-cycle vectors
      for (int i = 0; i < 18; i++) begin
         start_i = tbl[i].st; capture_i = tbl[i].cap; rst_capture_i = tbl[i].rc;
         rd_req_i = tbl[i].rd; rd_ch_i = tbl[i].ch;
         tick();
         chk($sformatf("vec%0d_valid", i), rd_valid_o, tbl[i].v);
         chk($sformatf("vec%0d_data", i), rd_data_o, tbl[i].d);
         chk($sformatf("vec%0d_empty", i), rd_empty_o, tbl[i].emp);
         chk($sformatf("vec%0d_running", i), running_o, tbl[i].run);
      end
      start_i = '0; capture_i = '0; rst_capture_i = '0; rd_req_i = 1'b0;

      // ch2 start, capture 100 cycles later
      do_sreset();
      start_i = 4'b0100; tick(); start_i = '0;
      repeat (100) tick();
      capture_i = 4'b0100; tick(); capture_i = '0;
      chk("t1_empty", rd_empty_o, 4'b1011);
      chk("t1_running", running_o, 4'b0100);
      pop(2, 1, 100, "t1_pop");

      // overflow on ch0 after five captures without pops
      do_sreset();
      start_i = 4'b0001; tick(); start_i = '0;
      repeat (5) tick();
      capture_i = 4'b0001;
      repeat (4) tick();
      chk("t2_ovf_full", ovf_o, 4'b0000);
      tick();
      capture_i = '0;
      chk("t2_ovf", ovf_o, 4'b0001);
      pop(0, 1, 5, "t2_pop5");
      pop(0, 1, 6, "t2_pop6");
      pop(0, 1, 7, "t2_pop7");
      pop(0, 1, 8, "t2_pop8");
      pop(0, 0, 0, "t2_pop_empty");
      chk("t2_hold_data", rd_data_o, 8);
      // ch1 full with same-cycle pop: no overflow
      start_i = 4'b0010; tick(); start_i = '0;
      capture_i = 4'b0010;
      repeat (4) tick();
      rd_req_i = 1'b1; rd_ch_i = 2'd1; tick(); rd_req_i = 1'b0; capture_i = '0;
      chk("t2_fullpop_valid", rd_valid_o, 1);
      chk("t2_fullpop_data", rd_data_o, 0);
      chk("t2_fullpop_ovf", ovf_o, 4'b0001);
      pop(1, 1, 1, "t2_ch1_pop1");
      pop(1, 1, 2, "t2_ch1_pop2");
      pop(1, 1, 3, "t2_ch1_pop3");
      pop(1, 1, 4, "t2_ch1_pop4");
      rst_capture_i = 4'b0001; tick(); rst_capture_i = '0;
      chk("t2_ovf_cleared", ovf_o, 4'b0000);

      // one-shot alarm 37 on ch1
      do_sreset();
      alarm_value_i[1*W +: W] = 37; alarm_en_i = 4'b0010; alarm_periodic_i = '0;
      start_i = 4'b0010; tick(); start_i = '0;
      hits = 0; at = -1; run37 = 1'b0; run38 = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         tick();
         if (alarm_o != 0) begin hits += $countones(alarm_o); at = k; end
         if (k == 37) run37 = running_o[1];
         if (k == 38) run38 = running_o[1];
      end
      chk("t3_hits", hits, 1);
      chk("t3_cycle", at, 38);
      chk("t3_run_before", run37, 1);
      chk("t3_run_after", run38, 0);
      capture_i = 4'b0010; tick(); capture_i = '0;
      pop(1, 1, 37, "t3_pop");
      alarm_en_i = '0;

      // periodic alarm 9 on ch3
      do_sreset();
      alarm_value_i[3*W +: W] = 9; alarm_en_i = 4'b1000; alarm_periodic_i = 4'b1000;
      start_i = 4'b1000; tick(); start_i = '0;
      hits = 0; at = -1; last = -1; gap_ok = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         tick();
         if (alarm_o[3]) begin
            hits++;
            if (last < 0) at = k;
            else if (k - last != 10) gap_ok = 1'b0;
            last = k;
         end
      end
      chk("t4_hits", hits, 5);
      chk("t4_first", at, 10);
      chk("t4_spacing", gap_ok, 1);
      chk("t4_running", running_o, 4'b1000);
      alarm_en_i = '0; alarm_periodic_i = '0;
      rst_capture_i = 4'b1000; tick(); rst_capture_i = '0;
      chk("t4_stopped", running_o, 4'b0000);

      // rst_capture with capture same cycle, restart, single entry 200
      do_sreset();
      start_i = 4'b0100; tick(); start_i = '0;
      repeat (50) tick();
      rst_capture_i = 4'b0100; capture_i = 4'b0100; tick(); rst_capture_i = '0; capture_i = '0;
      chk("t5_empty", rd_empty_o, 4'b1111);
      chk("t5_running", running_o, 4'b0000);
      start_i = 4'b0100; tick(); start_i = '0;
      repeat (200) tick();
      capture_i = 4'b0100; tick(); capture_i = '0;
      pop(2, 1, 200, "t5_pop");
      pop(2, 0, 0, "t5_pop_empty");

      // 8-bit wrap on the narrow instance
      do_sreset();
      start_i = 4'b0001; tick(); start_i = '0;
      repeat (300) tick();
      chk("t6_wrap8", wrap8, 4'b0001);
      chk("t6_wrap32", wrap_o, 4'b0000);
      capture_i = 4'b0001; tick(); capture_i = '0;
      chk("t6_empty8", empty8, 4'b1110);
      rd_req_i = 1'b1; rd_ch_i = 2'd0; tick(); rd_req_i = 1'b0;
      chk("t6_valid8", rd_valid8, 1);
      chk("t6_data8", rd_data8, 44);
      capture_i = 4'b0011; tick(); capture_i = '0;
      do_sreset();
      chk("t6_sreset_wrap8", wrap8, 0);
      chk("t6_sreset_empty8", empty8, 4'b1111);
      chk("t6_sreset_empty", rd_empty_o, 4'b1111);
      chk("t6_sreset_running8", running8, 0);

      // asynchronous reset mid-cycle
      start_i = 4'b0001; tick(); start_i = '0;
      repeat (3) tick();
      capture_i = 4'b0001; tick(); capture_i = '0;
      pop(0, 1, 3, "t7_pop");
      capture_i = 4'b0001; tick(); capture_i = '0;
      #2 areset_n = 1'b0;
      #1;
      chk("t7_async_data", rd_data_o, 0);
      chk("t7_async_empty", rd_empty_o, 4'b1111);
      chk("t7_async_running", running_o, 4'b0000);
      @(negedge clk);
      areset_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multi_channel_capture_timer.md
# multi_channel_capture_timer

Parametrised multi-channel timer: NB_CHANNELS independent elapsed-time counters, each started by a pulse, with a per-channel timestamp capture FIFO and a programmable one-shot or periodic alarm. It supersedes the single-capture timer instance. Captured timestamps drain through one shared read port. The block sits beside the timer BFM and scoreboard as the DUT for the per-instance start, capture, rst_capture and alarm test suites.

## Interface
- TIMER_BITWIDTH, 32, counter and timestamp width
- NB_CHANNELS, 10, number of independent channels
- CAPTURE_DEPTH, 4, capture FIFO entries per channel (power of 2, ≥2)
- CH_W, $clog2(NB_CHANNELS) (min 1), read-channel select width

- clk  in  1  single clock, rising edge
- areset_n  in  1  asynchronous reset, active-low; clears all state
- sreset  in  1  synchronous reset, active-high; same effect as areset_n on next edge
- start_i  in  NB_CHANNELS  per-channel pulse: restart counter from 0 and run
- capture_i  in  NB_CHANNELS  per-channel pulse: push current count into FIFO
- rst_capture_i  in  NB_CHANNELS  per-channel pulse: stop, zero counter, flush FIFO, clear flags
- alarm_en_i  in  NB_CHANNELS  per-channel alarm enable (level)
- alarm_periodic_i  in  NB_CHANNELS  1 = periodic, 0 = one-shot (level)
- alarm_value_i  in  NB_CHANNELS*TIMER_BITWIDTH  per-channel compare value; channel c at [c*W +: W]
- rd_req_i  in  1  pop request for channel rd_ch_i
- rd_ch_i  in  CH_W  channel to read
- rd_valid_o  out  1  rd_data_o valid (one-cycle pulse)
- rd_data_o  out  TIMER_BITWIDTH  popped timestamp
- rd_empty_o  out  NB_CHANNELS  per-channel FIFO empty
- running_o  out  NB_CHANNELS  channel counter running
- alarm_o  out  NB_CHANNELS  one-cycle alarm pulse
- ovf_o  out  NB_CHANNELS  sticky: capture dropped because FIFO full
- wrap_o  out  NB_CHANNELS  sticky: counter wrapped past all-ones

## Operation
- Reset values: rd_valid_o=0, rd_data_o=0, rd_empty_o=all 1, running_o=0, alarm_o=0, ovf_o=0, wrap_o=0, all counts 0, alarm disarmed.
- Per-channel state machine: IDLE (count held) -> RUN on start_i. RUN -> RUN on start_i (restart at 0, rearm). RUN -> IDLE on rst_capture_i, or on one-shot alarm match. IDLE -> IDLE on rst_capture_i.
- RUN: count increments by 1 per cycle, modulo 2^TIMER_BITWIDTH. Transition all-ones -> 0 sets wrap_o.
- Alarm armed on start_i if alarm_en_i=1 that cycle; alarm_en_i=0 in any cycle disarms.
- Match is count == alarm_value while RUN and armed.
  - One-shot: pulse alarm_o, disarm, enter IDLE holding the match value.
  - Periodic: pulse alarm_o, count reloads to 0 next cycle, stay armed. Period = alarm_value+1 cycles; value 0 fires every cycle.
- Capture pushes the count register value sampled in the capture_i cycle, in RUN or IDLE. FIFO full and no same-cycle pop on that channel -> entry dropped, ovf_o set. Full with same-cycle pop -> both happen, no overflow.
- Per-channel priority, same cycle:
  - rst_capture_i beats start_i and capture_i; FIFO ends empty, flags clear.
  - capture_i with start_i stores the pre-restart count.
  - A capture on the match cycle stores alarm_value.
- Read: rd_req_i with rd_ch_i < NB_CHANNELS and channel not empty pops the oldest entry. rd_req_i on an empty channel or an out-of-range rd_ch_i is ignored; rd_valid_o stays 0, rd_data_o holds its value.
- Channels are fully independent; simultaneous events on different channels never interact.

## Timing
- start_i sampled at edge N: count=0 and running_o=1 after N; count=k after edge N+k.
- Match on count register during cycle M: alarm_o high during cycle M+1 for exactly one cycle. One-shot running_o falls at the same edge. Periodic count=0 after that edge.
- One-shot alarm_value=V after start at edge N: alarm_o high in cycle N+V+1.
- Capture at edge E: entry visible (rd_empty_o deasserts) after E.
- rd_req_i at edge R: rd_data_o/rd_valid_o valid after R, one cycle; rd_empty_o updates after R.
- rst_capture_i at edge E: running_o=0, rd_empty_o[c]=1, ovf_o/wrap_o[c]=0 after E; an alarm_o pulse scheduled for E+1 is suppressed.
- areset_n assertion clears immediately, independent of clk. Deassertion is synchronised externally. Reset mid-run loses FIFO contents.

## Test plan
- W=32, CH=4, DEPTH=4. Start ch2, capture 100 cycles later -> pop returns 100. Other channels: rd_empty_o=1, running_o=0.
- Start ch0, capture at +5,+6,+7,+8,+9 with no pops -> ovf_o[0]=1 after fifth. Pops return 5,6,7,8; a fifth pop gives rd_valid_o=0.
- One-shot alarm_value=37 on ch1 -> alarm_o[1] pulses in cycle start+38 only, running_o[1]=0. A capture 10 cycles later returns 37.
- Periodic alarm_value=9 on ch3 for 50 cycles -> 5 alarm_o pulses spaced 10 cycles apart.
- Start, 50 cycles, rst_capture same cycle as capture, start, 200 cycles, capture -> single FIFO entry 200.
- W=8: run 300 cycles from start -> wrap_o=1, capture returns 44; sreset clears wrap_o and empties all FIFOs.
